// File: rtl/gc_stream_capture.sv
// Capture buffer for the garbler output stream: decodes the two-lane stream into
// typed records, queues them in a dual-write FIFO and drains them over valid/ready.
module gc_stream_capture #(
    parameter int S     = 16,
    parameter int K     = 128,
    parameter int CC    = 1,
    parameter int DEPTH = 64,
    parameter int CW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 tag,
    input  logic [S-1:0]               cid,
    input  logic [S-1:0]               index0,
    input  logic [S-1:0]               index1,
    input  logic [K-1:0]               data0,
    input  logic [K-1:0]               data1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_type,
    output logic [S-1:0]               out_cid,
    output logic [S-1:0]               out_index,
    output logic [K-1:0]               out_data,
    output logic                       overflow,
    output logic                       done,
    output logic [CW-1:0]              cnt_label,
    output logic [CW-1:0]              cnt_table,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [1:0]   rtype;
        logic [S-1:0] cid;
        logic [S-1:0] index;
        logic [K-1:0] data;
    } rec_t;

    typedef enum logic [1:0] {ST_RUN, ST_END, ST_DONE} state_t;

    rec_t          mem [DEPTH];
    rec_t          rec0, rec1, w0, head;
    logic          v0, v1, accept, pop, drop;
    logic [1:0]    nrec, npush;
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] level_q, free;
    state_t        state;

    always_comb begin
        rec0 = '0;
        rec1 = '0;
        v0   = 1'b0;
        v1   = 1'b0;
        rec0.cid   = cid;
        rec1.cid   = cid;
        rec0.data  = data0;
        rec1.data  = data1;
        rec0.index = index0;
        rec1.index = index1;
        if (tag[2]) begin
            v0 = tag[0];
            v1 = tag[1];
        end else begin
            case (tag[1:0])
                2'b01: begin
                    // key records carry their lane number, not the stream index
                    v0 = 1'b1;  v1 = 1'b1;
                    rec0.rtype = 2'd1;  rec1.rtype = 2'd1;
                    rec0.index = '0;    rec1.index = S'(1);
                end
                2'b10: begin
                    v0 = 1'b1;  v1 = 1'b1;
                    rec0.rtype = 2'd2;  rec1.rtype = 2'd2;
                end
                2'b11: begin
                    v0 = 1'b1;
                    rec0.rtype = 2'd3;
                    rec0.index = '0;
                end
                default: ;
            endcase
        end
    end

    // Compact so that a lone lane-1 record occupies the first write slot.
    always_comb begin
        w0     = v0 ? rec0 : rec1;
        nrec   = {1'b0, v0} + {1'b0, v1};
        accept = (state == ST_RUN) && (cid != S'(CC));
        free   = LW'(DEPTH) - level_q;
        npush  = 2'd0;
        if (accept) begin
            if (free >= LW'(nrec))
                npush = nrec;
            else if (free == LW'(1))
                npush = 2'd1;
        end
        drop = accept && (npush != nrec);
        pop  = (level_q != '0) && out_ready;
    end

    always_ff @(posedge clk) begin
        if (npush != 2'd0)
            mem[wp] <= w0;
        if (npush == 2'd2)
            mem[wp + AW'(1)] <= rec1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            cnt_label <= '0;
            cnt_table <= '0;
            state     <= ST_RUN;
            done      <= 1'b0;
        end else begin
            wp      <= wp + AW'(npush);
            rp      <= rp + AW'(pop);
            level_q <= level_q + LW'(npush) - LW'(pop);
            if (drop)
                overflow <= 1'b1;
            if (w0.rtype == 2'd0)
                cnt_label <= cnt_label + CW'(npush);
            if (w0.rtype == 2'd2)
                cnt_table <= cnt_table + CW'(npush);
            case (state)
                ST_RUN: if (cid == S'(CC)) state <= ST_END;
                ST_END: if (level_q == '0) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign head      = mem[rp];
    assign out_valid = (level_q != '0);
    assign out_type  = out_valid ? head.rtype : '0;
    assign out_cid   = out_valid ? head.cid   : '0;
    assign out_index = out_valid ? head.index : '0;
    assign out_data  = out_valid ? head.data  : '0;
    assign level     = level_q;

endmodule

// File: tb/tb_gc_stream_capture.sv
// Directed bench for gc_stream_capture: vector table for decode/ordering,
// hand sequences for overflow, end-of-stream and async reset.
module tb_gc_stream_capture;
    localparam int S = 16, K = 128, CC = 1, DEPTH = 8, CW = 32;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic [2:0]    tag = '0;
    logic [S-1:0]  cid = '0, index0 = '0, index1 = '0;
    logic [K-1:0]  data0 = '0, data1 = '0;
    logic          out_ready = 1'b0;
    logic          out_valid, overflow, done;
    logic [1:0]    out_type;
    logic [S-1:0]  out_cid, out_index;
    logic [K-1:0]  out_data;
    logic [CW-1:0] cnt_label, cnt_table;
    logic [LW-1:0] level;

    int tests = 0, fails = 0;

    gc_stream_capture #(.S(S), .K(K), .CC(CC), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .tag(tag), .cid(cid), .index0(index0), .index1(index1),
        .data0(data0), .data1(data1), .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_cid(out_cid), .out_index(out_index), .out_data(out_data),
        .overflow(overflow), .done(done), .cnt_label(cnt_label), .cnt_table(cnt_table),
        .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    tag;
        logic [S-1:0]  cid, i0, i1;
        logic [K-1:0]  d0, d1;
        logic          rdy;
        logic          e_valid;
        logic [1:0]    e_type;
        logic [S-1:0]  e_cid, e_index;
        logic [K-1:0]  e_data;
        logic [LW-1:0] e_level;
        logic [CW-1:0] e_clab, e_ctab;
    } vec_t;

    localparam logic [K-1:0] DA5 = {16{8'hA5}};
    localparam logic [K-1:0] T4  = 128'h7444_0000_0000_0000_0000_0000_0000_0004;
    localparam logic [K-1:0] T5  = 128'h7555_0000_0000_0000_0000_0000_0000_0005;
    localparam logic [K-1:0] K0  = 128'hC0C0_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [K-1:0] K1  = 128'hC1C1_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
    localparam logic [K-1:0] MM  = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001;
    localparam logic [K-1:0] L9  = 128'h0000_0000_0000_0000_0000_0000_0000_0999;

    task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic [S-1:0] c, input logic [S-1:0] a,
                         input logic [S-1:0] b, input logic r);
        tag = t; cid = c; index0 = a; index1 = b; out_ready = r;
        data0 = K'(a) | (K'(1) << 100);
        data1 = K'(b) | (K'(1) << 101);
    endtask

    vec_t vecs[10];
    int   drain[7] = '{12, 13, 14, 15, 16, 17, 20};

    initial begin
        //          tag     cid i0  i1  d0   d1  rdy  val typ cid idx data lvl clab ctab
        vecs[0] = '{3'b101, 0,  3,  0,  DA5, 0,  0,   1,  0,  0,  3,  DA5, 1,  1,   0};
        vecs[1] = '{3'b010, 0,  4,  5,  T4,  T5, 0,   1,  0,  0,  3,  DA5, 3,  1,   2};
        vecs[2] = '{3'b000, 0,  0,  0,  0,   0,  1,   1,  2,  0,  4,  T4,  2,  1,   2};
        vecs[3] = '{3'b000, 0,  0,  0,  0,   0,  1,   1,  2,  0,  5,  T5,  1,  1,   2};
        vecs[4] = '{3'b001, 0,  99, 77, K0,  K1, 1,   1,  1,  0,  0,  K0,  2,  1,   2};
        vecs[5] = '{3'b000, 0,  0,  0,  0,   0,  1,   1,  1,  0,  1,  K1,  1,  1,   2};
        vecs[6] = '{3'b011, 0,  55, 66, MM,  K1, 1,   1,  3,  0,  0,  MM,  1,  1,   2};
        vecs[7] = '{3'b110, 2,  8,  9,  K0,  L9, 1,   1,  0,  2,  9,  L9,  1,  2,   2};
        vecs[8] = '{3'b000, 0,  0,  0,  0,   0,  1,   0,  0,  0,  0,  0,   0,  2,   2};
        vecs[9] = '{3'b100, 0,  7,  7,  MM,  MM, 0,   0,  0,  0,  0,  0,   0,  2,   2};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.level", K'(level), 0);
        chk("rst.valid", K'(out_valid), 0);
        chk("rst.data", out_data, 0);
        chk("rst.flags", K'({overflow, done}), 0);
        chk("rst.cnt", K'({cnt_label, cnt_table}), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tag = vecs[i].tag; cid = vecs[i].cid; index0 = vecs[i].i0; index1 = vecs[i].i1;
            data0 = vecs[i].d0; data1 = vecs[i].d1; out_ready = vecs[i].rdy;
            step();
            chk($sformatf("v%0d.valid", i), K'(out_valid), K'(vecs[i].e_valid));
            chk($sformatf("v%0d.type", i),  K'(out_type),  K'(vecs[i].e_type));
            chk($sformatf("v%0d.cid", i),   K'(out_cid),   K'(vecs[i].e_cid));
            chk($sformatf("v%0d.index", i), K'(out_index), K'(vecs[i].e_index));
            chk($sformatf("v%0d.data", i),  out_data,      vecs[i].e_data);
            chk($sformatf("v%0d.level", i), K'(level),     K'(vecs[i].e_level));
            chk($sformatf("v%0d.clab", i),  K'(cnt_label), K'(vecs[i].e_clab));
            chk($sformatf("v%0d.ctab", i),  K'(cnt_table), K'(vecs[i].e_ctab));
        end

        // Fill to DEPTH, then a fully dropped cycle, then a partial drop.
        for (int c = 0; c < 4; c++) begin
            drive(3'b111, 0, S'(10 + 2 * c), S'(11 + 2 * c), 1'b0);
            step();
        end
        chk("full.level", K'(level), 8);
        chk("full.ovf", K'(overflow), 0);
        drive(3'b111, 0, 40, 41, 1'b0);
        step();
        chk("drop2.level", K'(level), 8);
        chk("drop2.ovf", K'(overflow), 1);
        chk("drop2.clab", K'(cnt_label), 10);
        chk("drop2.head", K'(out_index), 10);
        drive(3'b000, 0, 0, 0, 1'b1);
        step();
        chk("pop1.level", K'(level), 7);
        drive(3'b111, 0, 20, 21, 1'b1);
        step();
        chk("drop1.level", K'(level), 7);
        chk("drop1.clab", K'(cnt_label), 11);
        drive(3'b000, 0, 0, 0, 1'b1);
        for (int j = 0; j < 7; j++) begin
            chk($sformatf("drain%0d.index", j), K'(out_index), K'(drain[j]));
            step();
        end
        chk("drain.valid", K'(out_valid), 0);

        // End of stream: cid == CC stops capture, done follows the last pop.
        drive(3'b010, 0, 30, 31, 1'b0);
        step();
        chk("eos.ctab", K'(cnt_table), 4);
        drive(3'b111, S'(CC), 50, 51, 1'b0);
        step();
        chk("eos.level", K'(level), 2);
        chk("eos.clab", K'(cnt_label), 11);
        drive(3'b111, 0, 52, 53, 1'b1);
        step();
        chk("eos.pop1", K'({level, done}), K'({LW'(1), 1'b0}));
        step();
        chk("eos.pop2", K'({level, done}), K'({LW'(0), 1'b0}));
        step();
        chk("eos.done", K'(done), 1);
        step();
        step();
        chk("eos.ignore", K'({level, out_valid, done}), K'({LW'(0), 1'b0, 1'b1}));
        chk("eos.ignclab", K'(cnt_label), 11);

        // Async reset with records queued.
        #2 rst = 1'b1;
        #1 chk("rst2.done", K'(done), 0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(3'b111, 0, S'(c), S'(c + 1), 1'b0);
            step();
        end
        drive(3'b000, 0, 0, 0, 1'b1);
        repeat (3) step();
        out_ready = 1'b0;
        chk("pre.level", K'(level), 5);
        chk("pre.ovf", K'(overflow), 1);
        chk("pre.clab", K'(cnt_label), 8);
        #2 rst = 1'b1;
        #1;
        chk("arst.level", K'(level), 0);
        chk("arst.valid", K'(out_valid), 0);
        chk("arst.ovf", K'(overflow), 0);
        chk("arst.cnt", K'({cnt_label, cnt_table}), 0);
        rst = 1'b0;
        step();
        chk("post.level", K'(level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
